seg_display_driver: RTL and testbench



---
 rtl/seg_display_driver_if.sv | 25 ++
 rtl/seg_display_driver.sv | 150 +++++++++++++++
 tb/tb_seg_display_driver.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_driver_if.sv
// Write bus between the processor's sevenseg register and the display driver.
// The processor side drives value/load/hex and observes busy/digits.
interface seg_display_driver_if;
    logic [12:0] value;
    logic        load;
    logic        hex;
    logic        busy;
    logic [15:0] digits;

    modport master (
        output value,
        output load,
        output hex,
        input  busy,
        input  digits
    );

    modport slave (
        input  value,
        input  load,
        input  hex,
        output busy,
        output digits
    );
endinterface

// File: rtl/seg_display_driver.sv
// 13-bit value to four hex/BCD digits, time-multiplexed onto a
// 4-digit common-anode seven-segment display.
module seg_display_driver #(
    parameter int SCAN_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    seg_display_driver_if.slave  bus,
    input  logic                 blank_lz,
    output logic [3:0]           an,
    output logic [6:0]           seg,
    output logic                 dp
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [15:0]   digits_q;
    logic          fmt_hex_q;
    logic          busy_q;
    logic [12:0]   sh_q;
    logic [15:0]   bcd_q;
    logic [3:0]    step_q;
    logic [DW-1:0] div_q;
    logic [1:0]    idx_q;

    logic [15:0]   bcd_adj;
    logic [15:0]   bcd_next;
    logic [12:0]   sh_next;

    assign bus.busy   = busy_q;
    assign bus.digits = digits_q;

    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < 4; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5)
                bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
        end
    end

    assign bcd_next = {bcd_adj[14:0], sh_q[12]};
    assign sh_next  = {sh_q[11:0], 1'b0};

    // A new load always overrides an in-flight conversion, even on its final step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q  <= '0;
            fmt_hex_q <= 1'b0;
            busy_q    <= 1'b0;
            sh_q      <= '0;
            bcd_q     <= '0;
            step_q    <= '0;
        end else if (bus.load) begin
            if (bus.hex) begin
                digits_q  <= {3'b000, bus.value};
                fmt_hex_q <= 1'b1;
                busy_q    <= 1'b0;
            end else begin
                sh_q   <= bus.value;
                bcd_q  <= '0;
                step_q <= '0;
                busy_q <= 1'b1;
            end
        end else if (busy_q) begin
            bcd_q  <= bcd_next;
            sh_q   <= sh_next;
            step_q <= step_q + 4'd1;
            if (step_q == 4'd12) begin
                digits_q  <= bcd_next;
                fmt_hex_q <= 1'b0;
                busy_q    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            idx_q <= idx_q + 2'd1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    logic [3:0] nib;
    logic [3:0] zero_above;
    logic       blank;
    logic [6:0] glyph;

    always_comb begin
        nib = '0;
        case (idx_q)
            2'd0: nib = digits_q[3:0];
            2'd1: nib = digits_q[7:4];
            2'd2: nib = digits_q[11:8];
            2'd3: nib = digits_q[15:12];
            default: nib = '0;
        endcase
    end

    // zero_above[k]: digit k and everything above it are zero
    always_comb begin
        zero_above[3] = (digits_q[15:12] == 4'd0);
        zero_above[2] = zero_above[3] && (digits_q[11:8] == 4'd0);
        zero_above[1] = zero_above[2] && (digits_q[7:4] == 4'd0);
        zero_above[0] = 1'b0;
    end

    assign blank = blank_lz && zero_above[idx_q];

    always_comb begin
        glyph = 7'b1111111;
        case (nib)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
            default: glyph = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= 7'b1000000;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx_q);
            seg <= blank ? 7'b1111111 : glyph;
            dp  <= ~((idx_q == 2'd0) && fmt_hex_q);
        end
    end

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver: loads, conversion timing,
// blanking, restart/abort races, reset and scan sequencing.
module tb_seg_display_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       blank_lz;
    logic [3:0] an, an3;
    logic [6:0] seg, seg3;
    logic       dp, dp3;

    int n_checks = 0;
    int n_fail   = 0;

    seg_display_driver_if bus ();
    seg_display_driver_if bus3 ();

    assign bus3.value = bus.value;
    assign bus3.load  = bus.load;
    assign bus3.hex   = bus.hex;

    seg_display_driver #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    seg_display_driver #(.SCAN_DIV(3)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus3.slave),
        .blank_lz (blank_lz),
        .an       (an3),
        .seg      (seg3),
        .dp       (dp3)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GB = 7'b0000011;
    localparam logic [6:0] GC = 7'b1000110;
    localparam logic [6:0] GX = 7'b1111111;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int an_idx(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic load_word(input logic [12:0] v, input logic h);
        bus.value = v;
        bus.hex   = h;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.digits !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b digits=%h want 0/0000",
                     bus.busy, bus.digits);
        end
        n_checks++;
        if (an !== 4'b1110 || seg !== G0 || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pins: an=%b seg=%b dp=%b want 1110/1000000/1",
                     an, seg, dp);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_hex_load;
        logic [6:0] es;
        logic       ed;
        logic [3:0] seen;
        seen = '0;
        load_word(13'h1ABC, 1'b1);
        n_checks++;
        if (bus.digits !== 16'h1ABC || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hex_digits: digits=%h busy=%b want 1abc/0",
                     bus.digits, bus.busy);
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            es = GX;
            ed = 1'b1;
            case (an)
                4'b1110: begin es = GC; ed = 1'b0; end
                4'b1101: es = GB;
                4'b1011: es = GA;
                4'b0111: es = G1;
                default: es = GX;
            endcase
            n_checks++;
            if (an_idx(an) < 0) begin
                n_fail++;
                $display("FAIL hex_an: an=%b not one-hot-zero", an);
            end else begin
                seen[an_idx(an)] = 1'b1;
                if (seg !== es || dp !== ed) begin
                    n_fail++;
                    $display("FAIL hex_scan: an=%b seg=%b dp=%b want %b/%b",
                             an, seg, dp, es, ed);
                end
            end
            tick();
        end
        n_checks++;
        if (seen !== 4'b1111) begin
            n_fail++;
            $display("FAIL hex_frame: digits seen=%b want 1111", seen);
        end
    endtask

    task automatic test_decimal_max;
        load_word(13'd8191, 1'b0);
        for (int i = 0; i < 13; i++) begin
            n_checks++;
            if (bus.busy !== 1'b1 || bus.digits !== 16'h1ABC) begin
                n_fail++;
                $display("FAIL dec_busy[%0d]: busy=%b digits=%h want 1/1abc",
                         i, bus.busy, bus.digits);
            end
            tick();
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.digits !== 16'h8191) begin
            n_fail++;
            $display("FAIL dec_commit: busy=%b digits=%h want 0/8191",
                     bus.busy, bus.digits);
        end
    endtask

    task automatic test_blanking;
        logic [6:0] es;
        blank_lz = 1'b1;
        load_word(13'd7, 1'b0);
        for (int i = 0; i < 20 && bus.busy; i++) tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.digits !== 16'h0007) begin
            n_fail++;
            $display("FAIL blank_commit: busy=%b digits=%h want 0/0007",
                     bus.busy, bus.digits);
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            es = (an == 4'b1110) ? G7 : GX;
            n_checks++;
            if (seg !== es || dp !== 1'b1) begin
                n_fail++;
                $display("FAIL blank_on: an=%b seg=%b dp=%b want %b/1",
                         an, seg, dp, es);
            end
            tick();
        end
        blank_lz = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            es = (an == 4'b1110) ? G7 : G0;
            n_checks++;
            if (seg !== es) begin
                n_fail++;
                $display("FAIL blank_off: an=%b seg=%b want %b", an, seg, es);
            end
            tick();
        end
    endtask

    task automatic test_restart;
        load_word(13'd1234, 1'b0);
        repeat (4) tick();
        load_word(13'd42, 1'b0);
        for (int i = 0; i < 13; i++) begin
            n_checks++;
            if (bus.busy !== 1'b1 || bus.digits !== 16'h0007) begin
                n_fail++;
                $display("FAIL restart_hold[%0d]: busy=%b digits=%h want 1/0007",
                         i, bus.busy, bus.digits);
            end
            tick();
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.digits !== 16'h0042) begin
            n_fail++;
            $display("FAIL restart_commit: busy=%b digits=%h want 0/0042",
                     bus.busy, bus.digits);
        end
    endtask

    task automatic test_hex_abort;
        load_word(13'd999, 1'b0);
        repeat (3) tick();
        load_word(13'h0F0, 1'b1);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.digits !== 16'h00F0) begin
            n_fail++;
            $display("FAIL abort_hex: busy=%b digits=%h want 0/00f0",
                     bus.busy, bus.digits);
        end
        repeat (15) tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.digits !== 16'h00F0) begin
            n_fail++;
            $display("FAIL abort_hold: busy=%b digits=%h want 0/00f0",
                     bus.busy, bus.digits);
        end
    endtask

    task automatic test_final_edge_race;
        load_word(13'd100, 1'b0);
        repeat (12) tick();
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL race_pre: busy=%b want 1", bus.busy);
        end
        load_word(13'h055, 1'b1);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.digits !== 16'h0055) begin
            n_fail++;
            $display("FAIL race_load: busy=%b digits=%h want 0/0055",
                     bus.busy, bus.digits);
        end
        repeat (3) tick();
        n_checks++;
        if (bus.digits !== 16'h0055) begin
            n_fail++;
            $display("FAIL race_hold: digits=%h want 0055", bus.digits);
        end
    endtask

    task automatic test_reset_mid;
        load_word(13'h0123, 1'b1);
        load_word(13'd5, 1'b0);
        repeat (3) tick();
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: busy=%b want 1", bus.busy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.digits !== 16'h0000) begin
            n_fail++;
            $display("FAIL rstmid_state: busy=%b digits=%h want 0/0000",
                     bus.busy, bus.digits);
        end
        n_checks++;
        if (an !== 4'b1110 || seg !== G0 || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pins: an=%b seg=%b dp=%b want 1110/1000000/1",
                     an, seg, dp);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_scan_wrap;
        logic [3:0] s [24];
        logic [3:0] ea;
        int i0;
        int k0;
        for (int i = 0; i < 24; i++) begin
            s[i] = an3;
            n_checks++;
            if ($countones(~an3) != 1) begin
                n_fail++;
                $display("FAIL scan_onehot[%0d]: an=%b", i, an3);
            end
            tick();
        end
        i0 = -1;
        for (int i = 1; i < 4; i++) begin
            if (i0 < 0 && s[i] != s[i-1]) i0 = i;
        end
        n_checks++;
        if (i0 < 0) begin
            n_fail++;
            $display("FAIL scan_change: no an change in first 4 samples");
        end else begin
            k0 = an_idx(s[i0]);
            if (k0 < 0 || an_idx(s[i0-1]) != (k0 + 3) % 4) begin
                n_fail++;
                $display("FAIL scan_order: an %b -> %b", s[i0-1], s[i0]);
            end else begin
                for (int m = 0; i0 + m < 24; m++) begin
                    ea = ~(4'b0001 << ((k0 + m / 3) % 4));
                    n_checks++;
                    if (s[i0+m] !== ea) begin
                        n_fail++;
                        $display("FAIL scan_seq[%0d]: an=%b want %b",
                                 i0 + m, s[i0+m], ea);
                    end
                end
            end
        end
    endtask

    initial begin
        bus.value = '0;
        bus.hex   = 1'b0;
        bus.load  = 1'b0;
        blank_lz  = 1'b0;
        test_reset();
        test_hex_load();
        test_decimal_max();
        test_blanking();
        test_restart();
        test_hex_abort();
        test_final_edge_race();
        test_reset_mid();
        test_scan_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
